// File: rtl/ballot_if.sv
// Officer/voter bundle for the ballot controller.
// master drives commands and buttons; slave returns votes and status.
interface ballot_if;
  logic       open_poll;
  logic       close_poll;
  logic       authorize;
  logic       btn_C1;
  logic       btn_C2;
  logic       btn_C3;
  logic       vote_C1;
  logic       vote_C2;
  logic       vote_C3;
  logic       poll_open;
  logic       armed;
  logic       full;
  logic [3:0] ballot_cnt;
  logic       err_multi;
  logic       timeout;

  modport master (
    output open_poll, close_poll, authorize,
    output btn_C1, btn_C2, btn_C3,
    input  vote_C1, vote_C2, vote_C3,
    input  poll_open, armed, full, ballot_cnt,
    input  err_multi, timeout
  );

  modport slave (
    input  open_poll, close_poll, authorize,
    input  btn_C1, btn_C2, btn_C3,
    output vote_C1, vote_C2, vote_C3,
    output poll_open, armed, full, ballot_cnt,
    output err_multi, timeout
  );
endinterface

// File: rtl/ballot_controller.sv
// Ballot controller: one vote per authorized voter, with timeout.
// Ports: clk, rst (async high), bus (ballot_if.slave); all outputs registered.
module ballot_controller #(
  parameter int unsigned MAX_BALLOTS    = 15,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic    clk,
  input  logic    rst,
  ballot_if.slave bus
);

  typedef enum logic [1:0] {
    CLOSED,
    IDLE,
    ARMED,
    RELEASE
  } state_t;

  localparam logic [3:0]  MAX_CNT = 4'(MAX_BALLOTS);
  localparam logic [15:0] TMO     = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  prev_q;
  logic [2:0]  vote_q, vote_d;
  logic        err_q, err_d;
  logic        to_q, to_d;
  logic        po_q, po_d;
  logic        ar_q, ar_d;
  logic        full_q, full_d;

  logic [2:0]  btn;
  logic [2:0]  press;
  logic        single;
  logic        multi;

  assign btn   = {bus.btn_C3, bus.btn_C2, bus.btn_C1};
  // A held button is never a press: edge against last cycle.
  assign press = btn & ~prev_q;
  assign single = (press == 3'b001) ||
                  (press == 3'b010) ||
                  (press == 3'b100);
  assign multi  = (press != 3'b000) && !single;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    vote_d  = 3'b000;
    err_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      CLOSED: begin
        if (bus.open_poll) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      IDLE: begin
        if (bus.close_poll) begin
          state_d = CLOSED;
        end else if (bus.authorize && cnt_q < MAX_CNT) begin
          state_d = ARMED;
          timer_d = TMO;
        end
      end
      ARMED: begin
        if (bus.close_poll) begin
          state_d = CLOSED;
        end else if (single) begin
          vote_d  = press;
          cnt_d   = (cnt_q < MAX_CNT) ? cnt_q + 4'd1 : cnt_q;
          state_d = RELEASE;
        end else begin
          err_d   = multi;
          timer_d = timer_q - 16'd1;
          // Expiry edge: this decrement takes the timer to zero.
          if (timer_q <= 16'd1) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RELEASE: begin
        if (btn == 3'b000) state_d = IDLE;
      end
    endcase
    po_d   = (state_d != CLOSED);
    ar_d   = (state_d == ARMED);
    full_d = (cnt_d == MAX_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLOSED;
      timer_q <= 16'd0;
      cnt_q   <= 4'd0;
      prev_q  <= 3'b000;
      vote_q  <= 3'b000;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      po_q    <= 1'b0;
      ar_q    <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      prev_q  <= btn;
      vote_q  <= vote_d;
      err_q   <= err_d;
      to_q    <= to_d;
      po_q    <= po_d;
      ar_q    <= ar_d;
      full_q  <= full_d;
    end
  end

  assign bus.vote_C1    = vote_q[0];
  assign bus.vote_C2    = vote_q[1];
  assign bus.vote_C3    = vote_q[2];
  assign bus.poll_open  = po_q;
  assign bus.armed      = ar_q;
  assign bus.full       = full_q;
  assign bus.ballot_cnt = cnt_q;
  assign bus.err_multi  = err_q;
  assign bus.timeout    = to_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Bench for ballot_controller: vector table plus scoreboard queue.
// Observed word: {vote C3..C1, poll_open, armed, full, cnt[3:0], err, to}.
module tb_ballot_controller;

  logic clk;
  logic rst;

  ballot_if bif ();

  ballot_controller #(
    .MAX_BALLOTS   (15),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [5:0]  stim;
    logic [11:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] sb_exp[$];
  string       sb_nm[$];
  int          ncmp;
  int          nfail;

  function automatic logic [11:0] obs();
    return {bif.vote_C3, bif.vote_C2, bif.vote_C1,
            bif.poll_open, bif.armed, bif.full,
            bif.ballot_cnt, bif.err_multi, bif.timeout};
  endfunction

  task automatic check(string nm, logic [11:0] got, logic [11:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic add(string nm, logic [5:0] s, logic [11:0] e);
    vec_t v;
    v.nm   = nm;
    v.stim = s;
    v.exp  = e;
    tbl.push_back(v);
  endtask

  // stim = {open, close, auth, btn C3, C2, C1}
  task automatic apply(string nm, logic [5:0] s, logic [11:0] e);
    logic [11:0] w;
    string       n;
    {bif.open_poll, bif.close_poll, bif.authorize} = s[5:3];
    {bif.btn_C3, bif.btn_C2, bif.btn_C1}           = s[2:0];
    sb_exp.push_back(e);
    sb_nm.push_back(nm);
    @(posedge clk);
    #1;
    w = sb_exp.pop_front();
    n = sb_nm.pop_front();
    check(n, obs(), w);
  endtask

  initial begin
    ncmp  = 0;
    nfail = 0;
    rst   = 1'b1;
    {bif.open_poll, bif.close_poll, bif.authorize} = 3'b000;
    {bif.btn_C3, bif.btn_C2, bif.btn_C1}           = 3'b000;

    // exp = vote_po ar fu_cnt_err to
    add("closed_idle",    6'b000_000, 12'b000_000_0000_00);
    add("closed_auth",    6'b001_000, 12'b000_000_0000_00);
    add("open",           6'b100_000, 12'b000_100_0000_00);
    add("auth",           6'b001_000, 12'b000_110_0000_00);
    add("press_c2",       6'b000_010, 12'b010_100_0001_00);
    add("hold_c2",        6'b000_010, 12'b000_100_0001_00);
    add("release_c2",     6'b000_000, 12'b000_100_0001_00);
    add("auth_multi",     6'b001_000, 12'b000_110_0001_00);
    add("multi_c1c3",     6'b000_101, 12'b000_110_0001_10);
    add("multi_rel",      6'b000_000, 12'b000_110_0001_00);
    add("press_c3",       6'b000_100, 12'b100_100_0010_00);
    add("release_c3",     6'b000_000, 12'b000_100_0010_00);
    add("auth_to",        6'b001_000, 12'b000_110_0010_00);
    add("to_wait1",       6'b000_000, 12'b000_110_0010_00);
    add("to_wait2",       6'b000_000, 12'b000_110_0010_00);
    add("to_wait3",       6'b000_000, 12'b000_110_0010_00);
    add("timeout",        6'b000_000, 12'b000_100_0010_01);
    add("to_done",        6'b000_000, 12'b000_100_0010_00);
    add("auth_exp",       6'b001_000, 12'b000_110_0010_00);
    add("exp_wait1",      6'b000_000, 12'b000_110_0010_00);
    add("exp_wait2",      6'b000_000, 12'b000_110_0010_00);
    add("exp_wait3",      6'b000_000, 12'b000_110_0010_00);
    add("press_at_exp",   6'b000_001, 12'b001_100_0011_00);
    add("rel_exp",        6'b000_000, 12'b000_100_0011_00);
    add("auth_held_c1",   6'b001_001, 12'b000_110_0011_00);
    add("still_held",     6'b000_001, 12'b000_110_0011_00);
    add("let_go",         6'b000_000, 12'b000_110_0011_00);
    add("repress_c1",     6'b000_001, 12'b001_100_0100_00);
    add("rel_c1",         6'b000_000, 12'b000_100_0100_00);
    add("auth5",          6'b001_000, 12'b000_110_0100_00);
    add("press_c2b",      6'b000_010, 12'b010_100_0101_00);
    add("close_in_rel",   6'b010_010, 12'b000_100_0101_00);
    add("rel_c2b",        6'b000_000, 12'b000_100_0101_00);
    add("auth6",          6'b001_000, 12'b000_110_0101_00);
    add("close_vs_press", 6'b010_100, 12'b000_000_0101_00);
    add("closed_auth2",   6'b001_000, 12'b000_000_0101_00);
    add("reopen",         6'b100_000, 12'b000_100_0000_00);
    add("close_over_auth",6'b011_000, 12'b000_000_0000_00);
    add("reopen2",        6'b100_000, 12'b000_100_0000_00);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), 12'b0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].nm, tbl[i].stim, tbl[i].exp);

    // Fill the session to saturation.
    for (int i = 1; i <= 15; i++) begin
      logic       f;
      logic [3:0] c;
      c = 4'(i);
      f = (i == 15);
      apply("sat_auth",  6'b001_000,
            {3'b000, 1'b1, 1'b1, 1'b0, c - 4'd1, 2'b00});
      apply("sat_vote",  6'b000_001,
            {3'b001, 1'b1, 1'b0, f, c, 2'b00});
      apply("sat_rel",   6'b000_000,
            {3'b000, 1'b1, 1'b0, f, c, 2'b00});
    end
    apply("full_auth",   6'b001_000, 12'b000_101_1111_00);
    apply("full_press",  6'b001_010, 12'b000_101_1111_00);
    apply("full_rel",    6'b000_000, 12'b000_101_1111_00);
    apply("full_close",  6'b010_000, 12'b000_001_1111_00);
    apply("closed_hold", 6'b000_000, 12'b000_001_1111_00);
    apply("full_reopen", 6'b100_000, 12'b000_100_0000_00);

    // Asynchronous reset in the middle of a ballot.
    apply("arm_for_rst", 6'b001_000, 12'b000_110_0000_00);
    #2;
    {bif.btn_C3, bif.btn_C2, bif.btn_C1} = 3'b001;
    bif.authorize = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst", obs(), 12'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply("held_after_rst", 6'b000_001, 12'b000_000_0000_00);
    apply("open_held",      6'b100_001, 12'b000_100_0000_00);
    apply("auth_held2",     6'b001_001, 12'b000_110_0000_00);
    apply("held_no_vote",   6'b000_001, 12'b000_110_0000_00);
    apply("drop_btn",       6'b000_000, 12'b000_110_0000_00);
    apply("press_c1_after", 6'b000_001, 12'b001_100_0001_00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
